// File: rtl/imem_pipe.sv
// ============================================================================
// Module   : imem_pipe
// Purpose  : Single-cycle-latency instruction memory with a valid/ready fetch
//            port and a byte-enabled write port. Optional statistics counters
//            are built when IMEM_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_pipe #(
    parameter int MEM_DEPTH      = 4096,
    parameter int MEM_ADDR_WIDTH = 14,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic [31:0]             i_req_addr,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [DATA_WIDTH-1:0]   o_rsp_data,
    output logic                    o_rsp_err,
    input  logic                    i_wr_en,
    input  logic [31:0]             i_wr_addr,
    input  logic [DATA_WIDTH/8-1:0] i_wr_be,
    input  logic [DATA_WIDTH-1:0]   i_wr_data
`ifdef IMEM_STATS_EN
    ,
    output logic [31:0]             o_fetch_cnt,
    output logic [31:0]             o_stall_cnt
`endif
);

    localparam int c_BE_W  = DATA_WIDTH / 8;
    localparam int c_OFS   = $clog2(c_BE_W);
    localparam int c_IDX_W = MEM_ADDR_WIDTH - c_OFS;
    localparam int c_AW    = $clog2(MEM_DEPTH);
    localparam logic [c_IDX_W:0] c_DEPTH = (c_IDX_W + 1)'(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_err;

    logic [c_IDX_W-1:0]    w_req_idx;
    logic [c_IDX_W-1:0]    w_wr_idx;
    logic                  w_req_ok;
    logic                  w_wr_ok;
    logic                  w_accept;
    logic                  w_same_word;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic [DATA_WIDTH-1:0] w_rd_merged;

    assign w_req_idx = i_req_addr[MEM_ADDR_WIDTH-1:c_OFS];
    assign w_wr_idx  = i_wr_addr[MEM_ADDR_WIDTH-1:c_OFS];

    assign w_req_ok = (i_req_addr[c_OFS-1:0] == '0) && ({1'b0, w_req_idx} < c_DEPTH);
    assign w_wr_ok  = i_wr_en && !i_rst &&
                      (i_wr_addr[c_OFS-1:0] == '0) && ({1'b0, w_wr_idx} < c_DEPTH);

    // Reset forces ready high so the port looks idle while reset is held
    assign o_req_ready = i_rst || !r_rsp_valid || i_rsp_ready;
    assign w_accept    = i_req_valid && o_req_ready && !i_rst;

    assign w_same_word = w_wr_ok && (w_wr_idx == w_req_idx);
    assign w_rd_word   = mem[w_req_idx[c_AW-1:0]];

    // Write-first bypass: bytes written this cycle replace the stored bytes
    genvar gb;
    generate
        for (gb = 0; gb < c_BE_W; gb++) begin : g_byte
            assign w_rd_merged[gb*8 +: 8] = (w_same_word && i_wr_be[gb]) ?
                                            i_wr_data[gb*8 +: 8] : w_rd_word[gb*8 +: 8];
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (w_wr_ok) begin
            for (int b = 0; b < c_BE_W; b++) begin
                if (i_wr_be[b]) begin
                    mem[w_wr_idx[c_AW-1:0]][b*8 +: 8] <= i_wr_data[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= !w_req_ok;
            r_rsp_data  <= w_req_ok ? w_rd_merged : '0;
        end else if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_err   = r_rsp_err;

`ifdef IMEM_STATS_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_accept && (r_fetch_cnt != 32'hFFFF_FFFF)) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (r_rsp_valid && !i_rsp_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign o_fetch_cnt = r_fetch_cnt;
    assign o_stall_cnt = r_stall_cnt;
`endif

    // Upper address bits are intentionally not decoded
    logic w_unused_addr;
    assign w_unused_addr = &{1'b0, i_req_addr[31:MEM_ADDR_WIDTH], i_wr_addr[31:MEM_ADDR_WIDTH]};

endmodule

`default_nettype wire

// File: tb/tb_imem_pipe.sv
// ============================================================================
// Module   : tb_imem_pipe
// Purpose  : Randomized self-checking bench for imem_pipe against a
//            transaction-level memory/response-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_pipe;

    localparam int c_DEPTH = 4096;
    localparam int c_AWID  = 16;
    localparam int c_DW    = 32;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
`ifdef IMEM_STATS_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
    logic [31:0] ref_fetch;
    logic [31:0] ref_stall;
`endif

    logic [31:0] ref_mem [c_DEPTH];
    rsp_t        exp_q[$];
    int          n_vec;
    int          n_err;

    imem_pipe #(
        .MEM_DEPTH      (c_DEPTH),
        .MEM_ADDR_WIDTH (c_AWID),
        .DATA_WIDTH     (c_DW)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_addr  (req_addr),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_data  (rsp_data),
        .o_rsp_err   (rsp_err),
        .i_wr_en     (wr_en),
        .i_wr_addr   (wr_addr),
        .i_wr_be     (wr_be),
        .i_wr_data   (wr_data)
`ifdef IMEM_STATS_EN
        ,
        .o_fetch_cnt (fetch_cnt),
        .o_stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit addr_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (int'(a[15:2]) < c_DEPTH);
    endfunction

    // Reference behaviour for one rising edge, using the inputs currently driven
    task automatic model_edge();
        bit   accept;
        rsp_t r;
        int   idx;
        if (rst) begin
            exp_q.delete();
`ifdef IMEM_STATS_EN
            ref_fetch = 0;
            ref_stall = 0;
`endif
            return;
        end
        accept = req_valid && (exp_q.size() == 0 || rsp_ready);
`ifdef IMEM_STATS_EN
        if (exp_q.size() != 0 && !rsp_ready && ref_stall != 32'hFFFF_FFFF) ref_stall++;
        if (accept && ref_fetch != 32'hFFFF_FFFF) ref_fetch++;
`endif
        if (exp_q.size() != 0 && rsp_ready) void'(exp_q.pop_front());
        if (wr_en && addr_ok(wr_addr)) begin
            idx = int'(wr_addr[15:2]);
            for (int b = 0; b < 4; b++)
                if (wr_be[b]) ref_mem[idx][b*8 +: 8] = wr_data[b*8 +: 8];
        end
        if (accept) begin
            if (addr_ok(req_addr)) begin
                r.data = ref_mem[int'(req_addr[15:2])];
                r.err  = 1'b0;
            end else begin
                r.data = 32'h0;
                r.err  = 1'b1;
            end
            exp_q.push_back(r);
        end
    endtask

    task automatic cycle(input logic c_rst, input logic rv, input logic [31:0] ra,
                         input logic rr, input logic we, input logic [31:0] wa,
                         input logic [3:0] be, input logic [31:0] wd);
        rst = c_rst; req_valid = rv; req_addr = ra; rsp_ready = rr;
        wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
        #1;
        check("req_ready", req_ready, rst || exp_q.size() == 0 || rsp_ready);
        @(posedge clk);
        model_edge();
        #1;
        check("rsp_valid", rsp_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check("rsp_data", rsp_data, exp_q[0].data);
            check("rsp_err", rsp_err, exp_q[0].err);
        end
`ifdef IMEM_STATS_EN
        check("fetch_cnt", fetch_cnt, ref_fetch);
        check("stall_cnt", stall_cnt, ref_stall);
`endif
    endtask

    task automatic fetch(input logic [31:0] a, input logic rr);
        cycle(1'b0, 1'b1, a, rr, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic idle(input logic rr);
        cycle(1'b0, 1'b0, 32'h0, rr, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] wa;
        int          sel;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
        @(negedge clk);

        // Reset with a write and a fetch present: both must be ignored
        cycle(1'b1, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 4'hF, 32'h1234_5678);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
        check("rst_data", rsp_data, 32'h0);
        check("rst_err", rsp_err, 1'b0);

        // Define every word so random fetches have known contents
        for (int i = 0; i < c_DEPTH; i++)
            cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'(i * 4), 4'hF, $urandom);

        // Full write then fetch
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
        fetch(32'h10, 1'b1);
        check("wr_rd_valid", rsp_valid, 1'b1);
        check("wr_rd_data", rsp_data, 32'hDEAD_BEEF);
        check("wr_rd_err", rsp_err, 1'b0);

        // Same-cycle byte write and fetch returns merged new data
        cycle(1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 32'h10, 4'b0010, 32'h0000_AA00);
        check("wfirst_data", rsp_data, 32'hDEAD_AAEF);

        // Back-to-back fetches
        fetch(32'h0, 1'b1);
        fetch(32'h4, 1'b1);
        check("b2b_valid4", rsp_valid, 1'b1);
        fetch(32'h8, 1'b1);
        check("b2b_valid8", rsp_valid, 1'b1);
        check("b2b_data8", rsp_data, ref_mem[2]);
        idle(1'b1);
        check("drain_valid", rsp_valid, 1'b0);

        // Stall for three cycles with a competing request
        fetch(32'h10, 1'b1);
        for (int i = 0; i < 3; i++) begin
            fetch(32'h20, 1'b0);
            check("stall_data", rsp_data, 32'hDEAD_AAEF);
            check("stall_ready", req_ready, 1'b0);
        end
`ifdef IMEM_STATS_EN
        check("stall_cnt3", stall_cnt, 32'd3);
`endif

        // Reset while a response is stalled
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        check("rst_drop_valid", rsp_valid, 1'b0);
        fetch(32'h10, 1'b1);
        check("post_rst_data", rsp_data, 32'hDEAD_AAEF);

        // Misaligned and out-of-range fetches
        fetch(32'h2, 1'b1);
        check("misal_err", rsp_err, 1'b1);
        check("misal_data", rsp_data, 32'h0);
        fetch(32'h4000, 1'b1);
        check("oor_err", rsp_err, 1'b1);
        check("oor_data", rsp_data, 32'h0);

        // Dropped misaligned write must not disturb word 0x10
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h11, 4'hF, 32'h0BAD_0BAD);
        fetch(32'h10, 1'b1);
        check("drop_wr_data", rsp_data, 32'hDEAD_AAEF);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            a   = $urandom;
            sel = int'($urandom_range(0, 7));
            if (sel < 5) begin
                a[15:14] = 2'b00;
                a[1:0]   = 2'b00;
            end else if (sel == 5) begin
                a[1:0] = 2'($urandom_range(1, 3));
            end
            wa = ($urandom_range(0, 1) == 1) ? a : $urandom;
            if ($urandom_range(0, 3) != 0) wa[15:14] = 2'b00;
            if ($urandom_range(0, 3) != 0) wa[1:0] = 2'b00;
            cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), a,
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), wa,
                  4'($urandom), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
